// File: rtl/phase_sequencer.sv
// Phase sequencer: steps a 5-phase instruction cycle, handles run/stop/step
// control, halt on decoded HLT, and steals one-cycle debug memory slots at boundaries.
module phase_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        exec_pulse,
  input  logic        step,
  input  logic        halt,
  input  logic        dbg_req,
  output logic [4:0]  ph_en,
  output logic        dbg_gnt,
  output logic        mem_sel,
  output logic        running,
  output logic        halted,
  output logic [15:0] instr_count
);

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;
  localparam logic [1:0] ST_DBG  = 2'd3;

  localparam logic [2:0] PH_LAST = 3'd4;

  logic [1:0]  state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic        stop_pend_q, stop_pend_d;
  logic        step_mode_q, step_mode_d;
  logic [1:0]  ret_q, ret_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  bnd_nxt;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    stop_pend_d = stop_pend_q;
    step_mode_d = step_mode_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    bnd_nxt     = ST_RUN;

    case (state_q)
      ST_STOP: begin
        if (exec_pulse) begin
          state_d     = ST_RUN;
          phase_d     = '0;
          step_mode_d = 1'b0;
          stop_pend_d = 1'b0;
        end else if (step) begin
          state_d     = ST_RUN;
          phase_d     = '0;
          step_mode_d = 1'b1;
          stop_pend_d = 1'b0;
        end else if (dbg_req) begin
          state_d = ST_DBG;
          ret_d   = ST_STOP;
        end
      end

      ST_RUN: begin
        // Phase 4 is the instruction boundary: the only point where halt,
        // stop requests and debug steals take effect.
        if (phase_q >= PH_LAST) begin
          cnt_d       = cnt_q + 16'd1;
          stop_pend_d = 1'b0;
          step_mode_d = 1'b0;
          phase_d     = '0;
          if (halt)
            bnd_nxt = ST_HALT;
          else if (stop_pend_q || step_mode_q)
            bnd_nxt = ST_STOP;
          else
            bnd_nxt = ST_RUN;
          if (dbg_req) begin
            state_d = ST_DBG;
            ret_d   = bnd_nxt;
          end else begin
            state_d = bnd_nxt;
          end
        end else begin
          phase_d = phase_q + 3'd1;
          if (exec_pulse && !stop_pend_q)
            stop_pend_d = 1'b1;
        end
      end

      ST_HALT: begin
        if (dbg_req) begin
          state_d = ST_DBG;
          ret_d   = ST_HALT;
        end
      end

      ST_DBG: begin
        state_d = ret_q;
        phase_d = '0;
      end

      default: begin
        state_d = ST_STOP;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_STOP;
      phase_q     <= '0;
      stop_pend_q <= 1'b0;
      step_mode_q <= 1'b0;
      ret_q       <= ST_STOP;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      stop_pend_q <= stop_pend_d;
      step_mode_q <= step_mode_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
    end
  end

  // Outputs decode registered state only, so reset clears them without a clock.
  always_comb begin
    ph_en = '0;
    if (state_q == ST_RUN)
      ph_en = 5'b00001 << phase_q;
  end

  assign dbg_gnt     = (state_q == ST_DBG);
  assign mem_sel     = (state_q == ST_DBG);
  assign running     = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALT);
  assign instr_count = cnt_q;

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port exec_pulse  input  1  one-cycle pulse from the debounced exec button, acting as a run/stop toggle.
REQ-004 SHALL have port step  input  1  one-cycle pulse requesting execution of exactly one instruction.
REQ-005 SHALL have port halt  input  1  level from the instruction decoder, asserted for a decoded HLT.
REQ-006 SHALL have port dbg_req  input  1  level request for a debug memory slot; held until dbg_gnt is seen.
REQ-007 SHALL have port ph_en  output  5  one-hot phase clock-enables; ph_en[0] first, through ph_en[4] last.
REQ-008 SHALL have port dbg_gnt  output  1  one-cycle grant of the debug memory slot.
REQ-009 SHALL have port mem_sel  output  1  memory-port owner select: 1 = debug, 0 = datapath.
REQ-010 SHALL have port running  output  1  high in state RUN.
REQ-011 SHALL have port halted  output  1  high in state HALT.
REQ-012 SHALL have port instr_count  output  16  count of completed instructions.

Function
REQ-013 SHALL implement the states STOP, RUN, HALT and DBG, plus a 3-bit phase index 0..4, a stop_pend flag, a step_mode flag and a ret_state register.
REQ-014 ph_en SHALL equal one-hot(phase index) in RUN and all-zero in every other state; exactly one bit SHALL be high per RUN cycle.
REQ-015 Each RUN cycle SHALL advance the phase index 0->1->2->3->4; a cycle with phase index 4 SHALL be the instruction boundary.
REQ-016 In STOP, exec_pulse SHALL enter RUN at phase 0 on the next cycle with step_mode=0.
REQ-017 In STOP, step alone SHALL enter RUN at phase 0 with step_mode=1; when exec_pulse and step coincide, exec_pulse SHALL win.
REQ-018 In STOP with no exec_pulse or step, dbg_req SHALL enter DBG with ret_state=STOP.
REQ-019 In RUN, exec_pulse SHALL set stop_pend; further pulses SHALL be ignored while it is set.
REQ-020 In RUN, step SHALL be ignored.
REQ-021 halt SHALL be sampled only at the boundary cycle.
REQ-022 At the boundary, the next state SHALL be computed as nxt = HALT if halt, else STOP if stop_pend or step_mode, else RUN.
REQ-023 At the boundary, if dbg_req then the block SHALL enter DBG with ret_state=nxt; otherwise it SHALL enter nxt, with phase 0 when nxt is RUN.
REQ-024 instr_count SHALL increment by 1 at every boundary cycle, wrapping 0xFFFF->0x0000.
REQ-025 stop_pend and step_mode SHALL clear on every boundary.
REQ-026 DBG SHALL last exactly one cycle with dbg_gnt=1 and mem_sel=1, then enter ret_state; a return to RUN SHALL start at phase 0.
REQ-027 Debug-to-datapath handover latency SHALL be 0 cycles: mem_sel SHALL return to 0 in the first cycle after DBG.
REQ-028 After DBG, the block SHALL spend at least one cycle in ret_state before a new grant, even if dbg_req stays high.
REQ-029 dbg_req arriving mid-instruction SHALL wait for the boundary; worst-case grant latency from RUN SHALL be 5 cycles.
REQ-030 HALT SHALL ignore exec_pulse and step, SHALL grant dbg_req via DBG with ret_state=HALT, and SHALL be left only by reset.
REQ-031 dbg_gnt and mem_sel SHALL be 0 in every state except DBG.
REQ-032 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-033 Assertion of reset SHALL immediately, without waiting for clk, force: state STOP, phase 0, ph_en=5'b00000, dbg_gnt=0, mem_sel=0, running=0, halted=0, instr_count=0x0000, stop_pend=0, step_mode=0, ret_state=STOP.
REQ-034 Reset asserted mid-instruction or during DBG SHALL abort the operation with no pending request retained.
REQ-035 The first state change after reset release SHALL occur no earlier than the first rising clk edge with reset low.

Verification
REQ-036 Free run: reset, exec_pulse, 12 cycles -> ph_en = 00001,00010,00100,01000,10000 repeating; instr_count=2 after the 10th cycle; running=1.
REQ-037 Single step: from STOP, step -> exactly 5 ph_en cycles, then STOP with ph_en=0; instr_count=1; a further step during those 5 cycles has no effect.
REQ-038 Stop at boundary: exec_pulse during phase 1 -> phases 2..4 complete, then STOP; a second exec_pulse -> resumes at phase 0.
REQ-039 Debug steal: dbg_req raised at phase 2 in RUN -> dbg_gnt=1 and mem_sel=1 for one cycle immediately after phase 4, then phase 0 resumes; with dbg_req held high, the next grant follows the next boundary.
REQ-040 Halt: halt=1 at a boundary -> HALT, halted=1, ph_en=0; exec_pulse ignored; dbg_req granted with return to HALT; reset -> STOP.
REQ-041 Wrap and reset: preload by running 65535 instructions, one more -> instr_count=0x0000; asserting reset asynchronously mid-phase-3 -> all outputs 0 with no clk edge.
